ram_rd_streamer: RTL

Read-side stream engine that sits directly upstream of the read port of `dual_port_ram`. It turns a single (base address, length) command into a sequence of `rd`/`rd_add` strobes and captures the 64-bit `out` data into a small skid FIFO. The FIFO presents the data to a downstream consumer on a valid/ready stream with a last-beat marker. Credit accounting guarantees that no returned RAM word is ever dropped under consumer back-pressure.

---
 rtl/ram_rd_streamer_if.sv | 33 +++
 rtl/ram_rd_streamer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ram_rd_streamer_if.sv
// ram_rd_streamer_if
//   Bundles the signals of the read-side stream engine.
//   Command : start, base_add, len   (into engine); busy, done (out of engine)
//   RAM     : rd, rd_add              (out of engine); out (RAM read data in)
//   Stream  : m_data, m_valid, m_last (out of engine); m_ready (consumer in)
//   master = engine side, slave = environment side (command source, RAM, consumer).
interface ram_rd_streamer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64
);
   logic              start;
   logic [ADDR_W-1:0] base_add;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;
   logic              rd;
   logic [ADDR_W-1:0] rd_add;
   logic [DATA_W-1:0] out;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready;

   modport master (
      input  start, base_add, len, out, m_ready,
      output busy, done, rd, rd_add, m_data, m_valid, m_last
   );

   modport slave (
      output start, base_add, len, out, m_ready,
      input  busy, done, rd, rd_add, m_data, m_valid, m_last
   );
endinterface

// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer
//   Turns one (base_add, len) command into a run of RAM read strobes, captures
//   the returned words into a small FIFO and streams them out with valid/ready
//   and a last-beat marker. Reads are credit limited so that every word that
//   comes back from the RAM always has a FIFO slot waiting for it.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ram_rd_streamer_if.master (command, RAM read port, output stream)
module ram_rd_streamer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1,
   parameter int DEPTH  = 4
) (
   input logic                clk,
   input logic                rst_n,
   ram_rd_streamer_if.master  bus
);
   localparam int STAGES = RD_LAT;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH + RD_LAT + 2) + 1;
   localparam int RW     = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, cur_addr, rd_add_q;
   logic [ADDR_W:0]   remaining, cur_rem;
   // vld_pipe[0] is the registered rd strobe; vld_pipe[STAGES] marks the
   // edge on which the RAM word is on 'out' and gets captured.
   logic [STAGES:0]   vld_pipe, last_pipe;
   logic              load, issue, credit, done_q, done_nxt;
   logic              push, pop;
   beat_t             mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     fifo_cnt, inflight;

   // Reads in flight = issued but not yet captured (includes one being
   // captured this edge, so a same-cycle capture never frees a credit early).
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= STAGES; i++) inflight = inflight + CW'(vld_pipe[i]);
   end

   assign credit = (fifo_cnt + inflight) < CW'(DEPTH);
   assign push   = vld_pipe[STAGES];
   assign pop    = bus.m_valid && bus.m_ready;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      cur_addr  = addr;
      cur_rem   = remaining;
      case (state)
         IDLE: begin
            // The command is used directly so the first read can go out on
            // the same edge that accepts it.
            cur_addr = bus.base_add;
            cur_rem  = bus.len;
            if (bus.start && !done_q) begin
               if (bus.len == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  load      = 1'b1;
                  issue     = credit;
                  state_nxt = (credit && bus.len == RW'(1)) ? DRAIN : ISSUE;
               end
            end
         end
         ISSUE: begin
            issue = credit;
            if (credit && remaining == RW'(1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && bus.m_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- issue datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
         rd_add_q  <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= done_nxt;
         vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
         last_pipe <= {last_pipe[STAGES-1:0], issue && (cur_rem == RW'(1))};
         if (issue) begin
            rd_add_q  <= cur_addr;
            addr      <= cur_addr + ADDR_W'(1);  // wraps at 2^ADDR_W
            remaining <= cur_rem - RW'(1);
         end else if (load) begin
            addr      <= cur_addr;
            remaining <= cur_rem;
         end
      end
   end

   // ---------------- capture FIFO ----------------
   // Storage is reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{last: last_pipe[STAGES], data: bus.out};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (fifo_cnt < CW'(DEPTH)));

   // ---------------- outputs ----------------
   assign bus.m_valid = (fifo_cnt != '0);
   assign bus.m_data  = mem[rd_ptr].data;
   assign bus.m_last  = bus.m_valid && mem[rd_ptr].last;
   assign bus.rd      = vld_pipe[0];
   assign bus.rd_add  = rd_add_q;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
endmodule
